// File: rtl/frame_capture_writer_pkg.sv
// Shared types and constants for the frame capture writer: FSM states, CRC-16-CCITT
// constants, default frame geometry and the SDRAM word packing helper.
package frame_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } fc_state_e;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   localparam int          DEF_H_SIZE  = 800;
   localparam int          DEF_V_SIZE  = 480;
   localparam logic [22:0] DEF_WR_BASE = 23'd1152000;
   localparam int          PIX_CNT_W   = 19;

   // Same layout the frame read path unpacks.
   function automatic logic [31:0] pack_pixel(input logic [7:0] r,
                                              input logic [7:0] g,
                                              input logic [7:0] b);
      return {8'h00, b, g, r};
   endfunction

endpackage

// File: rtl/frame_capture_writer_if.sv
// SDRAM write-FIFO port driven by the frame capture writer.
interface frame_capture_writer_if;
   // oWR is a push strobe: one word transfers on every cycle oWR=1, there is no
   // acknowledge. iWR_FULL is back-pressure sampled together with the pixel strobe;
   // a word offered while it is high is dropped, never retried.
   logic        oWR;
   logic [31:0] oWR_DATA;
   logic [22:0] oWR_ADDR;
   logic        oWR_LOAD;
   logic        iWR_FULL;

   modport master (output oWR, oWR_DATA, oWR_ADDR, oWR_LOAD, input iWR_FULL);
   modport slave  (input oWR, oWR_DATA, oWR_ADDR, oWR_LOAD, output iWR_FULL);
endinterface

// File: rtl/frame_capture_writer_crc16_24.sv
// Combinational CRC-16-CCITT next-state function consuming 24 data bits per step,
// MSB first.
module crc16_24
   import frame_capture_pkg::*;
(
   input  logic [15:0] crc_i,
   input  logic [23:0] data_i,
   output logic [15:0] crc_o
);

   logic [15:0] c;

   always_comb begin
      c = crc_i;
      for (int i = 23; i >= 0; i--) begin
         if (c[15] ^ data_i[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
         else                   c = {c[14:0], 1'b0};
      end
      crc_o = c;
   end

endmodule

// File: rtl/frame_capture_writer.sv
// Captures one displayed frame from the clk_vga pixel stream into SDRAM as {00,B,G,R}
// words. Optional frame CRC output when FRAME_CAPTURE_CRC_EN is defined.
module frame_capture_writer
   import frame_capture_pkg::*;
#(
   parameter int          H_SIZE       = DEF_H_SIZE,
   parameter int          V_SIZE       = DEF_V_SIZE,
   parameter int          FRAME_PIXELS = H_SIZE * V_SIZE,
   parameter logic [22:0] WR_BASE      = DEF_WR_BASE
)
(
   input  logic                         clk_vga,
   input  logic                         dly_rstn,
   input  logic                         iCAPTURE,
   input  logic                         iVS,
   input  logic                         iDE,
   input  logic [7:0]                   iR,
   input  logic [7:0]                   iG,
   input  logic [7:0]                   iB,
   frame_capture_writer_if.master       wr,
   output logic                         oBUSY,
   output logic                         oDONE,
   output logic                         oOVERFLOW,
   output logic                         oSHORT,
`ifdef FRAME_CAPTURE_CRC_EN
   output logic [15:0]                  oCRC,
`endif
   output fc_state_e                    oDBG_STATE
);

   localparam logic [PIX_CNT_W-1:0] FRAME_CNT = PIX_CNT_W'(FRAME_PIXELS);
   localparam logic [PIX_CNT_W-1:0] LAST_CNT  = FRAME_CNT - 1'b1;

   fc_state_e              state_q, state_d;
   logic                   cap_meta_q, cap_sync_q, cap_prev_q;
   logic                   vs_prev_q;
   logic [PIX_CNT_W-1:0]   cnt_q, cnt_d;
   logic                   wr_q, wr_d;
   logic [31:0]            wr_data_q, wr_data_d;
   logic                   wr_load_q, wr_load_d;
   logic                   ovf_q, ovf_d;
   logic                   short_q, short_d;

   logic req, vs_fall, pix_take, pix_last, pix_write;

   assign req       = cap_sync_q & ~cap_prev_q;
   assign vs_fall   = vs_prev_q & ~iVS;
   // The saturation guard keeps pixels past the frame length from counting.
   assign pix_take  = (state_q == ST_CAPTURE) && iDE && (cnt_q != FRAME_CNT);
   assign pix_last  = pix_take && (cnt_q == LAST_CNT);
   assign pix_write = pix_take && !wr.iWR_FULL;

   always_ff @(posedge clk_vga or negedge dly_rstn) begin
      if (!dly_rstn) begin
         cap_meta_q <= 1'b0;
         cap_sync_q <= 1'b0;
         cap_prev_q <= 1'b0;
         vs_prev_q  <= 1'b1;
      end else begin
         cap_meta_q <= iCAPTURE;
         cap_sync_q <= cap_meta_q;
         cap_prev_q <= cap_sync_q;
         vs_prev_q  <= iVS;
      end
   end

   always_ff @(posedge clk_vga or negedge dly_rstn) begin
      if (!dly_rstn) state_q <= ST_IDLE;
      else           state_q <= state_d;
   end

   // Completion on the final pixel takes priority over a coincident VS edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (req)                 state_d = ST_ARMED;
         ST_ARMED:   if (vs_fall)             state_d = ST_CAPTURE;
         ST_CAPTURE: if (pix_last || vs_fall) state_d = ST_DONE;
         ST_DONE:                             state_d = ST_IDLE;
         default:                             state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      oBUSY = (state_q != ST_IDLE);
      oDONE = (state_q == ST_DONE);
   end

   always_comb begin
      cnt_d     = cnt_q;
      wr_d      = 1'b0;
      wr_data_d = wr_data_q;
      wr_load_d = 1'b0;
      ovf_d     = ovf_q;
      short_d   = short_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               ovf_d   = 1'b0;
               short_d = 1'b0;
            end
         end
         ST_ARMED: begin
            if (vs_fall) begin
               wr_load_d = 1'b1;
               cnt_d     = '0;
            end
         end
         ST_CAPTURE: begin
            if (pix_take) begin
               cnt_d = cnt_q + 1'b1;
               if (wr.iWR_FULL) begin
                  ovf_d = 1'b1;
               end else begin
                  wr_d      = 1'b1;
                  wr_data_d = pack_pixel(iR, iG, iB);
               end
            end
            if (vs_fall && !pix_last) short_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_vga or negedge dly_rstn) begin
      if (!dly_rstn) begin
         cnt_q     <= '0;
         wr_q      <= 1'b0;
         wr_data_q <= '0;
         wr_load_q <= 1'b0;
         ovf_q     <= 1'b0;
         short_q   <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         wr_q      <= wr_d;
         wr_data_q <= wr_data_d;
         wr_load_q <= wr_load_d;
         ovf_q     <= ovf_d;
         short_q   <= short_d;
      end
   end

`ifdef FRAME_CAPTURE_CRC_EN
   logic [15:0] crc_q, crc_d, crc_step;

   crc16_24 u_crc (
      .crc_i  (crc_q),
      .data_i ({iB, iG, iR}),
      .crc_o  (crc_step)
   );

   // Only words actually pushed to SDRAM contribute; the result holds until the next request.
   always_comb begin
      crc_d = crc_q;
      if ((state_q == ST_IDLE) && req) crc_d = CRC16_INIT;
      else if (pix_write)              crc_d = crc_step;
   end

   always_ff @(posedge clk_vga or negedge dly_rstn) begin
      if (!dly_rstn) crc_q <= CRC16_INIT;
      else           crc_q <= crc_d;
   end

   assign oCRC = crc_q;
`endif

   assign wr.oWR      = wr_q;
   assign wr.oWR_DATA = wr_data_q;
   assign wr.oWR_ADDR = WR_BASE;
   assign wr.oWR_LOAD = wr_load_q;
   assign oOVERFLOW   = ovf_q;
   assign oSHORT      = short_q;
   assign oDBG_STATE  = state_q;

endmodule

// File: tb/tb_frame_capture_writer.sv
// Bench for frame_capture_writer on a reduced 16x6 frame, randomized pixels and FIFO
// back-pressure, cycle model plus literal totals. Build with FRAME_CAPTURE_CRC_EN to cover oCRC.
module tb_frame_capture_writer;
   import frame_capture_pkg::*;

   localparam int          H     = 16;
   localparam int          V     = 6;
   localparam int          FRAME = H * V;
   localparam logic [22:0] BASE  = 23'd1152000;

   // ---------------- clock / reset ----------------
   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic       cap = 1'b0, vs = 1'b1, de = 1'b0, full = 1'b0;
   logic [7:0] r = 8'h00, g = 8'h00, b = 8'h00;
   logic       busy, done, ovf, shrt;
   fc_state_e  dbg;
`ifdef FRAME_CAPTURE_CRC_EN
   logic [15:0] crc;
`endif

   frame_capture_writer_if wr_bus ();
   assign wr_bus.iWR_FULL = full;

   frame_capture_writer #(
      .H_SIZE(H), .V_SIZE(V), .FRAME_PIXELS(FRAME), .WR_BASE(BASE)
   ) dut (
      .clk_vga   (clk),
      .dly_rstn  (rstn),
      .iCAPTURE  (cap),
      .iVS       (vs),
      .iDE       (de),
      .iR        (r),
      .iG        (g),
      .iB        (b),
      .wr        (wr_bus.master),
      .oBUSY     (busy),
      .oDONE     (done),
      .oOVERFLOW (ovf),
      .oSHORT    (shrt),
`ifdef FRAME_CAPTURE_CRC_EN
      .oCRC      (crc),
`endif
      .oDBG_STATE(dbg)
   );

   // ---------------- reference model ----------------
   function automatic logic [15:0] crc_ref(input logic [15:0] c_in, input logic [23:0] px);
      logic [15:0] c;
      logic [7:0]  by;
      c = c_in;
      for (int k = 2; k >= 0; k--) begin
         by = px[k*8 +: 8];
         c  = c ^ {by, 8'h00};
         for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
      return c;
   endfunction

   function automatic logic [15:0] const_frame_crc();
      logic [15:0] c;
      c = 16'hFFFF;
      for (int k = 0; k < FRAME; k++) c = crc_ref(c, 24'hFFFFFF);
      return c;
   endfunction

   // Expected outputs after each edge: phase 0 idle, 1 armed, 2 capturing, 3 done.
   bit          m_h1, m_h2, m_h3, m_vs_last, m_wr, m_load, m_ovf, m_short;
   int          m_phase, m_cnt;
   logic [31:0] m_data;
   logic [15:0] m_crc;

   always @(posedge clk or negedge rstn) begin : model
      bit req, fall, last_px;
      if (!rstn) begin
         m_h1 <= 0; m_h2 <= 0; m_h3 <= 0; m_vs_last <= 1;
         m_phase <= 0; m_cnt <= 0; m_wr <= 0; m_load <= 0;
         m_ovf <= 0; m_short <= 0; m_crc <= 16'hFFFF; m_data <= '0;
      end else begin
         req     = m_h2 && !m_h3;
         fall    = m_vs_last && !vs;
         last_px = 0;
         m_h1 <= cap; m_h2 <= m_h1; m_h3 <= m_h2; m_vs_last <= vs;
         m_wr <= 0; m_load <= 0;
         case (m_phase)
            0: if (req) begin m_phase <= 1; m_ovf <= 0; m_short <= 0; m_crc <= 16'hFFFF; end
            1: if (fall) begin m_phase <= 2; m_load <= 1; m_cnt <= 0; end
            2: begin
               if (de) begin
                  if (full) m_ovf <= 1;
                  else begin
                     m_wr   <= 1;
                     m_data <= {8'h00, b, g, r};
                     m_crc  <= crc_ref(m_crc, {b, g, r});
                  end
                  m_cnt   <= m_cnt + 1;
                  last_px = (m_cnt + 1 == FRAME);
               end
               if (fall && !last_px) m_short <= 1;
               if (last_px || fall) m_phase <= 3;
            end
            default: m_phase <= 0;
         endcase
      end
   end

   // ---------------- scoreboard ----------------
   int          n_checks = 0, n_fail = 0;
   int          n_wr = 0, n_load = 0, n_done = 0;
   int          s_wr, s_load, s_done;
   logic [31:0] first_word = '0, last_word = '0;
   logic [15:0] done_crc = '0;
   bit          first_pending = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_loop();
      forever begin
         @(negedge clk);
         if (rstn) begin
            check("oWR",       32'(wr_bus.oWR),      32'(m_wr));
            check("oWR_LOAD",  32'(wr_bus.oWR_LOAD), 32'(m_load));
            check("oBUSY",     32'(busy),            32'(m_phase != 0));
            check("oDONE",     32'(done),            32'(m_phase == 3));
            check("oOVERFLOW", 32'(ovf),             32'(m_ovf));
            check("oSHORT",    32'(shrt),            32'(m_short));
            check("oWR_ADDR",  32'(wr_bus.oWR_ADDR), 32'(BASE));
`ifdef FRAME_CAPTURE_CRC_EN
            check("oCRC",      32'(crc),             32'(m_crc));
`endif
            if (m_wr) check("oWR_DATA", wr_bus.oWR_DATA, m_data);
            if (wr_bus.oWR_LOAD) begin n_load++; first_pending = 1; end
            if (wr_bus.oWR) begin
               n_wr++;
               last_word = wr_bus.oWR_DATA;
               if (first_pending) begin first_word = wr_bus.oWR_DATA; first_pending = 0; end
            end
            if (done) begin
               n_done++;
`ifdef FRAME_CAPTURE_CRC_EN
               done_crc = crc;
`endif
            end
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic snap();
      s_wr = n_wr; s_load = n_load; s_done = n_done;
   endtask

   task automatic check_reset_outputs();
      check("rst_oWR",       32'(wr_bus.oWR),      32'd0);
      check("rst_oWR_DATA",  wr_bus.oWR_DATA,      32'd0);
      check("rst_oWR_LOAD",  32'(wr_bus.oWR_LOAD), 32'd0);
      check("rst_oBUSY",     32'(busy),            32'd0);
      check("rst_oDONE",     32'(done),            32'd0);
      check("rst_oOVERFLOW", 32'(ovf),             32'd0);
      check("rst_oSHORT",    32'(shrt),            32'd0);
      check("rst_state",     32'(dbg),             32'(ST_IDLE));
`ifdef FRAME_CAPTURE_CRC_EN
      check("rst_oCRC",      32'(crc),             32'h0000FFFF);
`endif
   endtask

   task automatic request();
      cap = 1'b1; step(5); cap = 1'b0; step(2);
   endtask

   // pix_mode: 0 counter {A5,idx}, 1 random, 2 constant FFFFFF.
   // full_mode: 0 never, 1 on pixels 20..29, 2 random.
   task automatic drive_frame(input int pix_mode, input int full_mode, input int stop_after,
                              input int cap_at, input bit vs_on_last, input int rst_at);
      int          idx;
      logic [23:0] pix;
      idx = 0;
      vs = 1'b0; step(2); vs = 1'b1; step(3);
      for (int l = 0; l < V; l++) begin
         for (int p = 0; p < H; p++) begin
            if (stop_after >= 0 && idx == stop_after) begin
               de = 1'b0; full = 1'b0; cap = 1'b0;
               return;
            end
            if (idx == rst_at) begin
               check("F_ovf_before_reset", 32'(ovf), 32'd1);
               rstn = 1'b0; #1;
               check_reset_outputs();
            end
            case (pix_mode)
               0:       pix = {8'hA5, 16'(idx)};
               1:       pix = 24'($urandom);
               default: pix = 24'hFFFFFF;
            endcase
            {b, g, r} = pix;
            de = 1'b1;
            if (full_mode == 1)      full = (idx >= 20 && idx < 30);
            else if (full_mode == 2) full = ($urandom_range(0, 5) == 0);
            else                     full = 1'b0;
            if (idx == cap_at) cap = 1'b1;
            if (vs_on_last && idx == FRAME - 1) vs = 1'b0;
            step(1);
            if (idx == rst_at) rstn = 1'b1;
            idx++;
         end
         de = 1'b0; full = 1'b0;
         step($urandom_range(3, 6));
      end
      step(3);
      vs = 1'b1; cap = 1'b0;
      step(2);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [15:0] crc1;
      int          stop;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      check("crc_ref_123456789",
            32'(crc_ref(crc_ref(crc_ref(16'hFFFF, 24'h313233), 24'h343536), 24'h373839)), 32'h000029B1);
      check("crc_ref_empty_step", 32'(crc_ref(16'h0000, 24'h000000)), 32'h00000000);
      rstn = 1'b1;
      step(2);
      fork compare_loop(); join_none

      // Plain full frame with counter pixels.
      snap(); request(); drive_frame(0, 0, -1, -1, 0, -1); step(4);
      check("A_writes", n_wr - s_wr, FRAME);
      check("A_loads",  n_load - s_load, 1);
      check("A_done",   n_done - s_done, 1);
      check("A_first",  first_word, 32'h00A50000);
      check("A_last",   last_word,  32'h00A5005F);
      check("A_short",  32'(shrt), 32'd0);
      check("A_ovf",    32'(ovf),  32'd0);

      // No request: nothing happens.
      snap(); drive_frame(1, 0, -1, -1, 0, -1);
      check("idle_writes", n_wr - s_wr, 0);

      // Request mid-frame waits for the next VS edge.
      snap(); drive_frame(0, 0, -1, 40, 0, -1);
      check("B_no_writes", n_wr - s_wr, 0);
      check("B_armed",     32'(busy), 32'd1);
      drive_frame(0, 0, -1, -1, 0, -1); step(4);
      check("B_writes", n_wr - s_wr, FRAME);
      check("B_first",  first_word, 32'h00A50000);
      check("B_done",   n_done - s_done, 1);

      // Ten pixels hit a full FIFO.
      snap(); request(); drive_frame(0, 1, -1, -1, 0, -1); step(4);
      check("C_writes", n_wr - s_wr, FRAME - 10);
      check("C_ovf",    32'(ovf), 32'd1);
      check("C_done",   n_done - s_done, 1);
      check("C_last",   last_word, 32'h00A5005F);

      // Frame cut after 40 pixels by the next VS edge.
      snap(); request(); drive_frame(0, 0, 40, -1, 0, -1); drive_frame(1, 0, -1, -1, 0, -1);
      check("D_writes", n_wr - s_wr, 40);
      check("D_short",  32'(shrt), 32'd1);
      check("D_done",   n_done - s_done, 1);
      check("D_loads",  n_load - s_load, 1);
      check("D_last",   last_word, 32'h00A50027);

      // VS falls on the final pixel: completion wins.
      snap(); request(); drive_frame(0, 0, -1, -1, 1, -1); step(4);
      check("E_writes", n_wr - s_wr, FRAME);
      check("E_short",  32'(shrt), 32'd0);
      check("E_done",   n_done - s_done, 1);

      // Reset at pixel 50; pixel 49's write is cancelled by the reset itself.
      snap(); request(); drive_frame(0, 1, -1, -1, 0, 50);
      check("F_writes_before_reset", n_wr - s_wr, 39);
      check("F_no_done", n_done - s_done, 0);
      snap(); request(); drive_frame(0, 0, -1, -1, 0, -1); step(4);
      check("F_clean_writes", n_wr - s_wr, FRAME);
      check("F_clean_ovf",    32'(ovf), 32'd0);
      check("F_clean_done",   n_done - s_done, 1);

      // Randomized captures.
      for (int k = 0; k < 4; k++) begin
         stop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, FRAME - 5)) : -1;
         snap(); request(); drive_frame(1, 2, stop, -1, 0, -1);
         if (stop >= 0) drive_frame(1, 0, -1, -1, 0, -1);
         check("G_done", n_done - s_done, 1);
      end

      // Constant white frame twice: CRC must match the model and repeat.
      request(); drive_frame(2, 0, -1, -1, 0, -1);
      crc1 = done_crc;
      request(); drive_frame(2, 0, -1, -1, 0, -1);
`ifdef FRAME_CAPTURE_CRC_EN
      check("H_crc_model",  32'(crc1), 32'(const_frame_crc()));
      check("H_crc_repeat", 32'(done_crc), 32'(crc1));
`endif

      step(5);
      exp_q.delete();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
